// File: rtl/shift8_ser_tx.sv
// Parallel-to-serial transmitter: takes a word on a valid/ready load port and
// shifts it out one bit per enabled clock, LSB first by default.
// Optional feature macro: SHIFT8_TX_PARITY_EN appends an even-parity bit per frame.
module shift8_ser_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             sd_en,
    output logic             sd_out,
    output logic             sd_valid,
    output logic             sd_first,
    output logic             sd_last,
    output logic             busy
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SHIFT8_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               accept;
    logic               last_bit;
    logic [WIDTH-1:0]   shreg_adv;

`ifdef SHIFT8_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    // Data bit currently on the wire and the register after one bit is consumed.
    assign last_bit  = (cnt_q == CNT_LAST);
    assign shreg_adv = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, shreg_q[WIDTH-1:1]};

    // Ready while idle, or on the enabled last data bit when no parity cycle follows.
`ifdef SHIFT8_TX_PARITY_EN
    assign load_ready = (state_q == IDLE);
`else
    assign load_ready = (state_q == IDLE) |
                        ((state_q == SHIFT) & sd_en & last_bit);
`endif
    assign accept = load_valid & load_ready;

    // State, shift register and bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef SHIFT8_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef SHIFT8_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic: load, shift on enable, wrap or finish at the last bit.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SHIFT8_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = load_data;
                    cnt_d   = '0;
`ifdef SHIFT8_TX_PARITY_EN
                    par_d   = ^load_data;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sd_en) begin
                    if (last_bit) begin
                        cnt_d = '0;
`ifdef SHIFT8_TX_PARITY_EN
                        state_d = PAR;
`else
                        if (accept) begin
                            shreg_d = load_data;
                            state_d = SHIFT;
                        end else begin
                            shreg_d = '0;
                            state_d = IDLE;
                        end
`endif
                    end else begin
                        shreg_d = shreg_adv;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef SHIFT8_TX_PARITY_EN
            PAR: begin
                if (sd_en) begin
                    shreg_d = '0;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        sd_out   = 1'b0;
        sd_valid = 1'b0;
        sd_first = 1'b0;
        sd_last  = 1'b0;
        busy     = 1'b0;
        case (state_q)
            SHIFT: begin
                sd_out   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                sd_valid = 1'b1;
                sd_first = (cnt_q == '0);
`ifndef SHIFT8_TX_PARITY_EN
                sd_last  = last_bit;
`endif
                busy     = 1'b1;
            end
`ifdef SHIFT8_TX_PARITY_EN
            PAR: begin
                sd_out   = par_q;
                sd_valid = 1'b1;
                sd_last  = 1'b1;
                busy     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift8_ser_tx.sv
// Bench for shift8_ser_tx: an LSB-first and an MSB-first instance share all
// inputs and are compared every cycle against a frame/bit-index model.
module tb_shift8_ser_tx;

    localparam int W = 8;
`ifdef SHIFT8_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         sd_en;

    logic rdy_l, out_l, val_l, fst_l, lst_l, bsy_l;
    logic rdy_m, out_m, val_m, fst_m, lst_m, bsy_m;

    int checks   = 0;
    int failures = 0;

    // Model: frame in flight, its word, and index of the bit on the wire.
    bit           active = 1'b0;
    int           idx    = 0;
    logic [W-1:0] word   = '0;

    always #5 clk = ~clk;

    shift8_ser_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(rdy_l),
        .load_data(load_data), .sd_en(sd_en), .sd_out(out_l), .sd_valid(val_l),
        .sd_first(fst_l), .sd_last(lst_l), .busy(bsy_l)
    );

    shift8_ser_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(rdy_m),
        .load_data(load_data), .sd_en(sd_en), .sd_out(out_m), .sd_valid(val_m),
        .sd_first(fst_m), .sd_last(lst_m), .busy(bsy_m)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, check, then advance the model.
    task automatic step(input logic lv, input logic [W-1:0] d, input logic en, input logic rn);
        logic e_rdy, e_val, e_fst, e_lst, e_out_l, e_out_m;
        @(negedge clk);
        reset_n    = rn;
        load_valid = lv;
        load_data  = d;
        sd_en      = en;
        if (!rn) active = 1'b0;
        #1;
        if (!active) begin
            e_rdy = 1'b1; e_val = 1'b0; e_fst = 1'b0; e_lst = 1'b0;
            e_out_l = 1'b0; e_out_m = 1'b0;
        end else begin
            e_val = 1'b1;
            e_fst = (idx == 0);
            e_lst = (idx == FL - 1);
            e_rdy = (FL == W) && en && (idx == FL - 1);
            if (idx < W) begin
                e_out_l = word[idx];
                e_out_m = word[W - 1 - idx];
            end else begin
                e_out_l = ^word;
                e_out_m = ^word;
            end
        end
        chk("lsb.ready", rdy_l, e_rdy);  chk("msb.ready", rdy_m, e_rdy);
        chk("lsb.valid", val_l, e_val);  chk("msb.valid", val_m, e_val);
        chk("lsb.busy",  bsy_l, e_val);  chk("msb.busy",  bsy_m, e_val);
        chk("lsb.first", fst_l, e_fst);  chk("msb.first", fst_m, e_fst);
        chk("lsb.last",  lst_l, e_lst);  chk("msb.last",  lst_m, e_lst);
        chk("lsb.out",   out_l, e_out_l); chk("msb.out",  out_m, e_out_m);
        @(posedge clk);
        if (rn) begin
            if (active && en) begin
                idx++;
                if (idx == FL) active = 1'b0;
            end
            if (lv && e_rdy) begin
                word   = d;
                idx    = 0;
                active = 1'b1;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; load_valid = 1'b0; load_data = '0; sd_en = 1'b0;

        // Power-on reset, including a valid load that must be ignored.
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);

        // 8'hA5 with sd_en held high; 8'h01 exercises the MSB-first last-bit case.
        step(1'b1, 8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < FL + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'h01, 1'b1, 1'b1);
        for (int i = 0; i < FL + 1; i++) step(1'b0, 8'hFF, 1'b1, 1'b1);

        // 8'h3C then 8'hC3 offered continuously until taken on the last bit.
        step(1'b1, 8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < FL + 1; i++) step(1'b1, 8'hC3, 1'b1, 1'b1);
        for (int i = 0; i < FL + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

        // 8'hFF with enable pattern 1,0,0,1 repeating.
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 4 * FL + 4; i++)
            step(1'b0, 8'h00, (i % 4 == 0) || (i % 4 == 3), 1'b1);

        // 8'h07: odd popcount, so the parity bit is 1 when that build is selected.
        step(1'b1, 8'h07, 1'b1, 1'b1);
        for (int i = 0; i < FL + 1; i++) step(1'b1, 8'h99, 1'b1, 1'b1);
        for (int i = 0; i < FL + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

        // Reset in mid-frame, then a clean frame.
        step(1'b1, 8'h6D, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hB2, 1'b1, 1'b1);
        for (int i = 0; i < FL + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

        // Randomized traffic, with changing data and rare resets.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 149) != 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
